// File: rtl/spi_tx_shifter.sv
// spi_tx_shifter
// Transmit-side shift engine for the soft SPI master. Words arrive over a
// valid/ready handshake into a one-entry holding register, are moved into a
// shift register and serialised onto MOSI one bit per SCLK period. Control
// runs on SCLK rising edges; MOSI is launched on falling edges so the peer
// samples each bit mid-period on the following rising edge.
//
// Ports
//   SCLK          serial clock, all inputs synchronous to it
//   reset_n       synchronous active-low reset
//   tx_data       word to transmit
//   tx_valid      tx_data valid
//   tx_ready      holding register empty
//   shift         shift enable, 0 freezes the bit position
//   burst         a new word is expected right after the current frame
//   clr_underrun  clears the sticky underrun flag
//   MOSI          serial data out
//   busy          a frame is being shifted
//   frame_done    one-cycle pulse after the last bit of a frame
//   underrun      sticky burst-underrun flag
//
// state | meaning
// IDLE  | nothing shifting, MOSI parked at IDLE_MOSI, waiting for hold_full
// SHIFT | sreg driving MOSI, bit_cnt tracks the bit currently on the line

module spi_tx_shifter #(
    parameter int   DATA_W    = 8,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_MOSI = 1'b1
) (
    input  logic              SCLK,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic              shift,
    input  logic              burst,
    input  logic              clr_underrun,
    output logic              MOSI,
    output logic              busy,
    output logic              frame_done,
    output logic              underrun
);

    localparam int               CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] hold;
    logic [DATA_W-1:0] sreg;
    logic [DATA_W-1:0] sreg_shifted;
    logic              hold_full;
    logic [CNT_W-1:0]  bit_cnt;
    logic              accept;
    logic              load;
    logic              advance;
    logic              frame_end;
    logic              set_underrun;
    logic              last_bit;

    // Ready comes from the registered flag only, so a word moved into sreg
    // frees the holding register one cycle later (no same-cycle refill).
    assign tx_ready = !hold_full;
    assign accept   = tx_valid && !hold_full;
    assign last_bit = (bit_cnt == LAST_BIT);
    assign busy     = (state == SHIFT);

    always_comb begin
        if (MSB_FIRST) begin
            sreg_shifted = {sreg[DATA_W-2:0], 1'b0};
        end else begin
            sreg_shifted = {1'b0, sreg[DATA_W-1:1]};
        end
    end

    always_ff @(posedge SCLK) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        load         = 1'b0;
        advance      = 1'b0;
        frame_end    = 1'b0;
        set_underrun = 1'b0;
        case (state)
            IDLE: begin
                if (hold_full) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (shift) begin
                    if (last_bit) begin
                        frame_end = 1'b1;
                        // A word already waiting is reloaded for a zero-gap frame.
                        if (hold_full) begin
                            load = 1'b1;
                        end else begin
                            state_nxt    = IDLE;
                            set_underrun = burst;
                        end
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Control flags. accept and load are mutually exclusive because accept
    // needs the holding register empty and load needs it full.
    always_ff @(posedge SCLK) begin
        if (!reset_n) begin
            hold_full  <= 1'b0;
            bit_cnt    <= '0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            if (accept) begin
                hold_full <= 1'b1;
            end else if (load) begin
                hold_full <= 1'b0;
            end

            if (load) begin
                bit_cnt <= '0;
            end else if (advance) begin
                bit_cnt <= bit_cnt + CNT_W'(1);
            end

            frame_done <= frame_end;

            if (set_underrun) begin
                underrun <= 1'b1;
            end else if (clr_underrun) begin
                underrun <= 1'b0;
            end
        end
    end

    // Data registers carry no reset; their contents only matter while the
    // matching valid flag or state says so.
    always_ff @(posedge SCLK) begin
        if (accept) begin
            hold <= tx_data;
        end
        if (load) begin
            sreg <= hold;
        end else if (advance) begin
            sreg <= sreg_shifted;
        end
    end

    always_ff @(negedge SCLK) begin
        if (!reset_n || state != SHIFT) begin
            MOSI <= IDLE_MOSI;
        end else if (MSB_FIRST) begin
            MOSI <= sreg[DATA_W-1];
        end else begin
            MOSI <= sreg[0];
        end
    end

endmodule

// File: tb/tb_spi_tx_shifter.sv
// Bench for spi_tx_shifter: an MSB-first and an LSB-first instance share the
// same stimulus and are compared every cycle against a word/bit-index model.

module tb_spi_tx_shifter;

    logic       SCLK = 1'b0;
    logic       reset_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       shift;
    logic       burst;
    logic       clr_underrun;

    logic tx_ready_m, mosi_m, busy_m, frame_done_m, underrun_m;
    logic tx_ready_l, mosi_l, busy_l, frame_done_l, underrun_l;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 SCLK = ~SCLK;

    spi_tx_shifter #(.DATA_W(8), .MSB_FIRST(1'b1), .IDLE_MOSI(1'b1)) u_msb (
        .SCLK(SCLK), .reset_n(reset_n), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready_m), .shift(shift), .burst(burst),
        .clr_underrun(clr_underrun), .MOSI(mosi_m), .busy(busy_m),
        .frame_done(frame_done_m), .underrun(underrun_m)
    );

    spi_tx_shifter #(.DATA_W(8), .MSB_FIRST(1'b0), .IDLE_MOSI(1'b1)) u_lsb (
        .SCLK(SCLK), .reset_n(reset_n), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready_l), .shift(shift), .burst(burst),
        .clr_underrun(clr_underrun), .MOSI(mosi_l), .busy(busy_l),
        .frame_done(frame_done_l), .underrun(underrun_l)
    );

    // Reference model: a pending word slot, the word in flight and the index
    // of the bit currently on the wire.
    logic [7:0] m_hold, m_cur;
    bit         m_hold_full, m_active, m_fd, m_ur, m_last_acc;
    int         m_idx;

    // Captured wire bits and event counters for the directed scenarios.
    logic [31:0] cap_m, cap_l;
    int          busy_cnt, fd_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic exp_bit(input bit msb_first);
        if (!m_active) return 1'b1;
        return msb_first ? m_cur[7 - m_idx] : m_cur[m_idx];
    endfunction

    task automatic model_update();
        bit was_full;
        bit take;
        bit set_ur;
        was_full   = m_hold_full;
        take       = 1'b0;
        set_ur     = 1'b0;
        m_last_acc = 1'b0;
        if (!reset_n) begin
            m_hold_full = 1'b0;
            m_active    = 1'b0;
            m_idx       = 0;
            m_fd        = 1'b0;
            m_ur        = 1'b0;
        end else begin
            m_fd = 1'b0;
            if (!m_active) begin
                take = was_full;
            end else if (shift) begin
                if (m_idx == 7) begin
                    m_fd = 1'b1;
                    if (was_full) begin
                        take = 1'b1;
                    end else begin
                        m_active = 1'b0;
                        set_ur   = burst;
                    end
                end else begin
                    m_idx++;
                end
            end
            if (take) begin
                m_cur       = m_hold;
                m_idx       = 0;
                m_active    = 1'b1;
                m_hold_full = 1'b0;
            end
            if (tx_valid && !was_full) begin
                m_hold      = tx_data;
                m_hold_full = 1'b1;
                m_last_acc  = 1'b1;
            end
            if (set_ur) m_ur = 1'b1;
            else if (clr_underrun) m_ur = 1'b0;
        end
    endtask

    // One SCLK period: model advances on the rising edge, flags are checked
    // 1 ns later, MOSI is checked just after the falling edge that launches it.
    task automatic step();
        @(posedge SCLK);
        model_update();
        #1;
        check("busy_m", busy_m, m_active);
        check("busy_l", busy_l, m_active);
        check("tx_ready_m", tx_ready_m, !m_hold_full);
        check("tx_ready_l", tx_ready_l, !m_hold_full);
        check("frame_done_m", frame_done_m, m_fd);
        check("frame_done_l", frame_done_l, m_fd);
        check("underrun_m", underrun_m, m_ur);
        check("underrun_l", underrun_l, m_ur);
        if (busy_m) busy_cnt++;
        if (frame_done_m) fd_cnt++;
        @(negedge SCLK);
        #1;
        check("mosi_m", mosi_m, exp_bit(1'b1));
        check("mosi_l", mosi_l, exp_bit(1'b0));
        if (m_active) begin
            cap_m = {cap_m[30:0], mosi_m};
            cap_l = {cap_l[30:0], mosi_l};
        end
    endtask

    task automatic clear_stats();
        cap_m    = '0;
        cap_l    = '0;
        busy_cnt = 0;
        fd_cnt   = 0;
    endtask

    task automatic send(input logic [7:0] w);
        tx_valid = 1'b1;
        tx_data  = w;
        for (int i = 0; i < 64; i++) begin
            step();
            if (m_last_acc) break;
        end
        check("send_accept", m_last_acc, 1'b1);
        tx_valid = 1'b0;
    endtask

    task automatic run_idle();
        for (int i = 0; i < 64; i++) begin
            if (!m_active && !m_hold_full) break;
            step();
        end
        check("idle_busy_m", busy_m, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n      = 1'b0;
        tx_data      = '0;
        tx_valid     = 1'b0;
        shift        = 1'b1;
        burst        = 1'b0;
        clr_underrun = 1'b0;
        m_hold       = '0;
        m_cur        = '0;
        m_hold_full  = 1'b0;
        m_active     = 1'b0;
        m_fd         = 1'b0;
        m_ur         = 1'b0;
        m_last_acc   = 1'b0;
        m_idx        = 0;
        clear_stats();

        step();
        step();
        check("rst_tx_ready", tx_ready_m, 1'b1);
        check("rst_mosi", mosi_m, 1'b1);
        reset_n = 1'b1;
        step();

        // Single frame 0xB4.
        clear_stats();
        send(8'hB4);
        run_idle();
        check("b4_msb_bits", cap_m[7:0], 8'hB4);
        check("b4_lsb_bits", cap_l[7:0], 8'h2D);
        check("b4_fd_count", fd_cnt, 1);
        check("b4_busy_cycles", busy_cnt, 8);
        check("b4_mosi_idle", mosi_m, 1'b1);

        // Back-to-back 0xA5 then 0x3C.
        clear_stats();
        send(8'hA5);
        send(8'h3C);
        run_idle();
        check("b2b_bits", cap_m[15:0], 16'hA53C);
        check("b2b_fd_count", fd_cnt, 2);
        check("b2b_busy_cycles", busy_cnt, 16);

        // 0xFF with shift frozen for 3 cycles after bit 2.
        clear_stats();
        send(8'hFF);
        step();
        step();
        step();
        shift = 1'b0;
        step();
        step();
        step();
        shift = 1'b1;
        run_idle();
        check("stall_busy_cycles", busy_cnt, 11);
        check("stall_fd_count", fd_cnt, 1);
        check("stall_bits", cap_m[7:0], 8'hFF);

        // Burst underrun with 0x81.
        burst = 1'b1;
        send(8'h81);
        run_idle();
        burst = 1'b0;
        check("ur_set", underrun_m, 1'b1);
        step();
        step();
        step();
        check("ur_sticky", underrun_m, 1'b1);
        clr_underrun = 1'b1;
        step();
        clr_underrun = 1'b0;
        check("ur_cleared", underrun_m, 1'b0);

        // Reset mid-frame of 0xC3 with 0x77 waiting in hold.
        send(8'hC3);
        send(8'h77);
        for (int i = 0; i < 16; i++) begin
            if (m_idx >= 4) break;
            step();
        end
        check("abort_reached_bit4", m_idx, 4);
        clear_stats();
        reset_n = 1'b0;
        step();
        check("abort_busy", busy_m, 1'b0);
        check("abort_tx_ready", tx_ready_m, 1'b1);
        check("abort_mosi", mosi_m, 1'b1);
        reset_n = 1'b1;
        step();
        step();
        check("abort_no_fd", fd_cnt, 0);
        check("abort_hold_dropped", busy_m, 1'b0);
        clear_stats();
        send(8'h5A);
        run_idle();
        check("post_abort_bits_m", cap_m[7:0], 8'h5A);
        check("post_abort_bits_l", cap_l[7:0], 8'h5A);

        // Randomised traffic against the model.
        for (int i = 0; i < 600; i++) begin
            tx_valid     = ($urandom_range(0, 2) != 0);
            tx_data      = 8'($urandom);
            shift        = ($urandom_range(0, 7) != 0);
            burst        = ($urandom_range(0, 3) == 0);
            clr_underrun = ($urandom_range(0, 15) == 0);
            reset_n      = ($urandom_range(0, 99) != 0);
            step();
        end
        tx_valid     = 1'b0;
        shift        = 1'b1;
        burst        = 1'b0;
        clr_underrun = 1'b0;
        reset_n      = 1'b1;
        run_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
